// File: rtl/ipsl_pcie_apb_mux_v2_0.sv
// APB address-decode router: one upstream master fanned out to NUM_TGT targets,
// with registered SETUP/ACCESS sequencing, unmapped/timeout error response and error stats.
module ipsl_pcie_apb_mux_v2_0 #(
  parameter int unsigned                NUM_TGT     = 3,
  parameter int unsigned                ADDR_W      = 16,
  parameter int unsigned                DATA_W      = 32,
  parameter logic [NUM_TGT*4-1:0]       TGT_LO      = {4'h8, 4'h7, 4'h0},
  parameter logic [NUM_TGT*4-1:0]       TGT_HI      = {4'hF, 4'h7, 4'h1},
  parameter int unsigned                TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0]          ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_up_p_sel,
  input  logic [DATA_W/8-1:0]       i_up_p_strb,
  input  logic [ADDR_W-1:0]         i_up_p_addr,
  input  logic [DATA_W-1:0]         i_up_p_wdata,
  input  logic                      i_up_p_ce,
  input  logic                      i_up_p_we,
  output logic                      o_up_p_rdy,
  output logic [DATA_W-1:0]         o_up_p_rdata,
  output logic                      o_up_p_err,
  output logic [NUM_TGT-1:0]        o_dn_p_sel,
  output logic [NUM_TGT-1:0]        o_dn_p_ce,
  output logic [DATA_W/8-1:0]       o_dn_p_strb,
  output logic [ADDR_W-1:0]         o_dn_p_addr,
  output logic [DATA_W-1:0]         o_dn_p_wdata,
  output logic                      o_dn_p_we,
  input  logic [NUM_TGT-1:0]        i_dn_p_rdy,
  input  logic [NUM_TGT*DATA_W-1:0] i_dn_p_rdata,
  output logic                      o_busy,
  output logic [15:0]               o_err_cnt,
  output logic [ADDR_W-1:0]         o_last_err_addr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TGT_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int unsigned WD_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [WD_W-1:0]     wd_q, wd_d, wd_inc;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   last_err_d;
  logic                timeout;

  logic [3:0]          region;
  logic                hit;
  logic [TGT_W-1:0]    hit_idx;
  logic                sel_rdy;
  logic [DATA_W-1:0]   sel_rdata;
  logic                setup_req;

  logic [NUM_TGT-1:0]  dn_sel_d, dn_ce_d;
  logic [STRB_W-1:0]   dn_strb_d;
  logic [ADDR_W-1:0]   dn_addr_d;
  logic [DATA_W-1:0]   dn_wdata_d;
  logic                dn_we_d;
  logic                up_rdy_d, up_err_d;
  logic [DATA_W-1:0]   up_rdata_d;

  function automatic logic [NUM_TGT-1:0] onehot(input logic [TGT_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx == TGT_W'(i)) onehot[i] = 1'b1;
    end
  endfunction

  assign region    = i_up_p_addr[ADDR_W-1 -: 4];
  assign setup_req = i_up_p_sel && !i_up_p_ce;
  assign wd_inc    = wd_q + WD_W'(1);
  assign timeout   = (TIMEOUT_CYC != 0) && (wd_inc == WD_W'(TIMEOUT_CYC));
  assign o_err_cnt = err_cnt_q;

  // Region decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (region >= TGT_LO[4*i +: 4] && region <= TGT_HI[4*i +: 4]) begin
        hit     = 1'b1;
        hit_idx = TGT_W'(i);
      end
    end
  end

  always_comb begin
    sel_rdy   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (tgt_q == TGT_W'(i)) begin
        sel_rdy   = i_dn_p_rdy[i];
        sel_rdata = i_dn_p_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (setup_req) state_d = hit ? ST_SETUP : ST_RESP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (sel_rdy || timeout) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of every registered output; downstream bus reads as zero outside SETUP/ACCESS.
  always_comb begin
    dn_sel_d   = '0;
    dn_ce_d    = '0;
    dn_strb_d  = '0;
    dn_addr_d  = '0;
    dn_wdata_d = '0;
    dn_we_d    = 1'b0;
    up_rdy_d   = 1'b0;
    up_err_d   = 1'b0;
    up_rdata_d = '0;
    tgt_d      = tgt_q;
    wd_d       = wd_q;
    err_cnt_d  = err_cnt_q;
    last_err_d = o_last_err_addr;
    case (state_q)
      ST_IDLE: begin
        if (setup_req) begin
          tgt_d = hit_idx;
          if (hit) begin
            dn_sel_d   = onehot(hit_idx);
            dn_strb_d  = i_up_p_strb;
            dn_addr_d  = i_up_p_addr;
            dn_wdata_d = i_up_p_wdata;
            dn_we_d    = i_up_p_we;
          end else begin
            up_rdy_d   = 1'b1;
            up_err_d   = 1'b1;
            up_rdata_d = ERR_RDATA;
            err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            last_err_d = i_up_p_addr;
          end
        end
      end
      ST_SETUP: begin
        dn_sel_d   = onehot(tgt_q);
        dn_ce_d    = onehot(tgt_q);
        dn_strb_d  = o_dn_p_strb;
        dn_addr_d  = o_dn_p_addr;
        dn_wdata_d = o_dn_p_wdata;
        dn_we_d    = o_dn_p_we;
        wd_d       = '0;
      end
      ST_ACCESS: begin
        if (sel_rdy) begin
          up_rdy_d   = 1'b1;
          up_rdata_d = sel_rdata;
        end else if (timeout) begin
          up_rdy_d   = 1'b1;
          up_err_d   = 1'b1;
          up_rdata_d = ERR_RDATA;
          err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
          last_err_d = o_dn_p_addr;
        end else begin
          dn_sel_d   = o_dn_p_sel;
          dn_ce_d    = o_dn_p_ce;
          dn_strb_d  = o_dn_p_strb;
          dn_addr_d  = o_dn_p_addr;
          dn_wdata_d = o_dn_p_wdata;
          dn_we_d    = o_dn_p_we;
          wd_d       = wd_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tgt_q           <= '0;
      wd_q            <= '0;
      err_cnt_q       <= '0;
      o_last_err_addr <= '0;
      o_dn_p_sel      <= '0;
      o_dn_p_ce       <= '0;
      o_dn_p_strb     <= '0;
      o_dn_p_addr     <= '0;
      o_dn_p_wdata    <= '0;
      o_dn_p_we       <= 1'b0;
      o_up_p_rdy      <= 1'b0;
      o_up_p_err      <= 1'b0;
      o_up_p_rdata    <= '0;
      o_busy          <= 1'b0;
    end else begin
      tgt_q           <= tgt_d;
      wd_q            <= wd_d;
      err_cnt_q       <= err_cnt_d;
      o_last_err_addr <= last_err_d;
      o_dn_p_sel      <= dn_sel_d;
      o_dn_p_ce       <= dn_ce_d;
      o_dn_p_strb     <= dn_strb_d;
      o_dn_p_addr     <= dn_addr_d;
      o_dn_p_wdata    <= dn_wdata_d;
      o_dn_p_we       <= dn_we_d;
      o_up_p_rdy      <= up_rdy_d;
      o_up_p_err      <= up_err_d;
      o_up_p_rdata    <= up_rdata_d;
      o_busy          <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ipsl_pcie_apb_mux_v2_0.sv
// Directed bench for the APB router: stimulus pushes expected responses, a monitor pops on o_up_p_rdy.
module tb_ipsl_pcie_apb_mux_v2_0;

  localparam int unsigned NT = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             up_sel, up_ce, up_we;
  logic [SW-1:0]    up_strb;
  logic [AW-1:0]    up_addr;
  logic [DW-1:0]    up_wdata;
  logic             o_up_p_rdy, o_up_p_err;
  logic [DW-1:0]    o_up_p_rdata;
  logic [NT-1:0]    o_dn_p_sel, o_dn_p_ce;
  logic [SW-1:0]    o_dn_p_strb;
  logic [AW-1:0]    o_dn_p_addr;
  logic [DW-1:0]    o_dn_p_wdata;
  logic             o_dn_p_we;
  logic [NT-1:0]    dn_rdy;
  logic [NT*DW-1:0] dn_rdata;
  logic             o_busy;
  logic [15:0]      o_err_cnt;
  logic [AW-1:0]    o_last_err_addr;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ipsl_pcie_apb_mux_v2_0 #(
    .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW),
    .TGT_LO({4'h8, 4'h7, 4'h0}), .TGT_HI({4'hF, 4'h7, 4'h1}),
    .TIMEOUT_CYC(TO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_up_p_sel(up_sel), .i_up_p_strb(up_strb), .i_up_p_addr(up_addr),
    .i_up_p_wdata(up_wdata), .i_up_p_ce(up_ce), .i_up_p_we(up_we),
    .o_up_p_rdy(o_up_p_rdy), .o_up_p_rdata(o_up_p_rdata), .o_up_p_err(o_up_p_err),
    .o_dn_p_sel(o_dn_p_sel), .o_dn_p_ce(o_dn_p_ce), .o_dn_p_strb(o_dn_p_strb),
    .o_dn_p_addr(o_dn_p_addr), .o_dn_p_wdata(o_dn_p_wdata), .o_dn_p_we(o_dn_p_we),
    .i_dn_p_rdy(dn_rdy), .i_dn_p_rdata(dn_rdata),
    .o_busy(o_busy), .o_err_cnt(o_err_cnt), .o_last_err_addr(o_last_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every upstream ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (o_up_p_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_up_rdy: got rdata %0h err %0b with nothing expected", o_up_p_rdata, o_up_p_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("up_rdata", 64'(o_up_p_rdata), 64'(e.rdata));
        chk("up_err", 64'(o_up_p_err), 64'(e.err));
      end
    end
  end

  // One upstream transfer starting at T0 (called just after a rising edge); tgt<0 = unmapped, waits<0 = never ready.
  task automatic xfer(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                      input int tgt, input int waits, input logic [DW-1:0] tdata,
                      input logic [DW-1:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input bit keep_sel);
    exp_t          e;
    int            lat;
    int            ce_cnt;
    logic [NT-1:0] exp_oh;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    exp_oh   = (tgt >= 0) ? NT'(1) << tgt : '0;
    up_sel   = 1'b1;
    up_ce    = 1'b0;
    up_addr  = addr;
    up_we    = we;
    up_wdata = wdata;
    up_strb  = 4'hF;
    lat      = 0;
    ce_cnt   = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) up_ce = 1'b1;
      if (tgt >= 0 && c >= 2) begin
        dn_rdy = '0;
        if (waits >= 0 && c - 2 == waits) begin
          dn_rdy[tgt]            = 1'b1;
          dn_rdata[DW*tgt +: DW] = tdata;
        end
      end
      @(negedge clk);
      if (c == 1) begin
        chk("dn_sel_T1", 64'(o_dn_p_sel), 64'(exp_oh));
        chk("dn_ce_T1", 64'(o_dn_p_ce), 64'(0));
        if (tgt >= 0) begin
          chk("dn_addr", 64'(o_dn_p_addr), 64'(addr));
          chk("dn_wdata", 64'(o_dn_p_wdata), 64'(wdata));
          chk("dn_we", 64'(o_dn_p_we), 64'(we));
        end
      end
      if (tgt >= 0 && o_dn_p_ce[tgt] === 1'b1) ce_cnt++;
      if (o_up_p_rdy === 1'b1) lat = c;
    end
    chk("up_rdy_latency", 64'(lat), 64'(exp_lat));
    if (tgt >= 0) chk("dn_ce_cycles", 64'(ce_cnt), 64'((waits < 0) ? int'(TO) : waits + 1));
    @(posedge clk); #1;
    dn_rdy = '0;
    up_ce  = 1'b0;
    if (!keep_sel) begin
      up_sel = 1'b0;
      @(negedge clk);
      chk("up_rdy_single_pulse", 64'(o_up_p_rdy), 64'(0));
      chk("idle_busy", 64'(o_busy), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    up_sel   = 1'b0;
    up_ce    = 1'b0;
    up_we    = 1'b0;
    up_strb  = '0;
    up_addr  = '0;
    up_wdata = '0;
    dn_rdy   = '0;
    dn_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_dn_sel", 64'(o_dn_p_sel), 64'(0));
    chk("rst_dn_ce", 64'(o_dn_p_ce), 64'(0));
    chk("rst_up_rdy", 64'(o_up_p_rdy), 64'(0));
    chk("rst_up_rdata", 64'(o_up_p_rdata), 64'(0));
    chk("rst_err_cnt", 64'(o_err_cnt), 64'(0));
    chk("rst_last_err", 64'(o_last_err_addr), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write to target 1, ready in the first access cycle.
    xfer(16'h7010, 1'b1, 32'h1234_5678, 1, 0, 32'h0, 32'h0, 1'b0, 3, 1'b0);
    // Read from target 0 after five wait cycles.
    xfer(16'h0004, 1'b0, 32'h0, 0, 5, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 8, 1'b0);
    // Unmapped region 3.
    xfer(16'h3000, 1'b0, 32'h0, -1, 0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    chk("err_cnt_after_unmapped", 64'(o_err_cnt), 64'(1));
    chk("last_err_unmapped", 64'(o_last_err_addr), 64'(16'h3000));
    // Target 2 never ready: watchdog fires after eight access cycles.
    xfer(16'h9000, 1'b0, 32'h0, 2, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, 10, 1'b0);
    chk("err_cnt_after_timeout", 64'(o_err_cnt), 64'(2));
    chk("last_err_timeout", 64'(o_last_err_addr), 64'(16'h9000));

    // sel and ce together while idle is not a setup phase.
    up_sel  = 1'b1;
    up_ce   = 1'b1;
    up_addr = 16'h7000;
    repeat (2) begin
      @(negedge clk);
      chk("sel_ce_idle_busy", 64'(o_busy), 64'(0));
      chk("sel_ce_idle_dn_sel", 64'(o_dn_p_sel), 64'(0));
      @(posedge clk); #1;
    end
    up_sel = 1'b0;
    up_ce  = 1'b0;
    @(posedge clk); #1;

    // Back-to-back with sel held: new setup in the cycle right after the ready pulse.
    xfer(16'h7000, 1'b0, 32'h0, 1, 0, 32'h1111_0001, 32'h1111_0001, 1'b0, 3, 1'b1);
    xfer(16'h1000, 1'b0, 32'h0, 0, 1, 32'h2222_0002, 32'h2222_0002, 1'b0, 4, 1'b0);

    // Error counter saturation from a preloaded value.
    force dut.err_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_cnt_q;
    chk("err_cnt_preload", 64'(o_err_cnt), 64'(16'hFFFE));
    xfer(16'h6000, 1'b0, 32'h0, -1, 0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    chk("err_cnt_reach_max", 64'(o_err_cnt), 64'(16'hFFFF));
    xfer(16'h3004, 1'b0, 32'h0, -1, 0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    chk("err_cnt_saturated", 64'(o_err_cnt), 64'(16'hFFFF));
    chk("last_err_saturated", 64'(o_last_err_addr), 64'(16'h3004));

    // Reset during ACCESS aborts the transfer with no upstream ready.
    up_sel  = 1'b1;
    up_ce   = 1'b0;
    up_addr = 16'h8000;
    up_we   = 1'b0;
    @(posedge clk); #1;
    up_ce = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_reset_dn_ce", 64'(o_dn_p_ce), 64'(3'b100));
    @(posedge clk); #1;
    up_sel = 1'b0;
    up_ce  = 1'b0;
    @(negedge clk);
    chk("abort_dn_sel", 64'(o_dn_p_sel), 64'(0));
    chk("abort_dn_ce", 64'(o_dn_p_ce), 64'(0));
    chk("abort_busy", 64'(o_busy), 64'(0));
    chk("abort_up_rdy", 64'(o_up_p_rdy), 64'(0));
    chk("abort_err_cnt", 64'(o_err_cnt), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
